// File: rtl/fifo_pixelq_pkg.sv
// Shared definitions for the pixel-queue FIFO family: default sizes,
// width helper and the occupancy update rule.
package fifo_pixelq_pkg;

    localparam int unsigned PIXQ_DATA_WIDTH = 12;
    localparam int unsigned PIXQ_DEPTH      = 3;

    // Ceiling log2, used to size read indices from a depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Occupancy after one edge, given the already-gated enables.
    function automatic int unsigned pixq_next_count(
        input int unsigned cnt,
        input logic        wr_en,
        input logic        rd_en
    );
        int unsigned result;
        result = cnt;
        unique case ({wr_en, rd_en})
            2'b10:   result = cnt + 1;
            2'b01:   result = cnt - 1;
            default: result = cnt;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fifo_pixelq_srl_store.sv
// Shift-register storage array: new word enters entry 0 on i_ce, words
// age toward higher indices; o_q_c is a combinational read at i_idx.
module fifo_pixelq_srl_store
    import fifo_pixelq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIXQ_DATA_WIDTH,
    parameter int unsigned DEPTH      = PIXQ_DEPTH,
    parameter int unsigned ADDR_WIDTH = clog2(PIXQ_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_ce,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_idx,
    output logic [DATA_WIDTH-1:0] o_q_c
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage carries no reset; the control side decides what is valid.
    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    // Index values beyond DEPTH-1 only occur while empty and read as zero.
    always_comb begin
        o_q_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_idx == ADDR_WIDTH'(i)) begin
                o_q_c = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/fifo_pixelq_srl_ctrl.sv
// First-word-fall-through pixel-queue FIFO on SRL storage with handshake
// flags and occupancy; almost_full/almost_empty exist only when
// FIFO_PIXELQ_ALMOST_FLAGS_EN is defined.
module fifo_pixelq_srl_ctrl
    import fifo_pixelq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIXQ_DATA_WIDTH,
    parameter int unsigned DEPTH      = PIXQ_DEPTH,
    parameter int unsigned ADDR_WIDTH = clog2(PIXQ_DEPTH)
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
    ,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [CW-1:0]         r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_shift;
    logic [CW-1:0]         w_next_count;
    logic [ADDR_WIDTH-1:0] w_head_idx;

    // Strobes only count when their flag allows them.
    assign w_wr_en      = if_write & r_full_n;
    assign w_rd_en      = if_read & r_empty_n;
    assign w_shift      = w_wr_en & reset_n;
    assign w_next_count = CW'(pixq_next_count(32'(r_count), w_wr_en, w_rd_en));
    // Oldest entry sits one below the occupancy.
    assign w_head_idx   = ADDR_WIDTH'(r_count - CW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_count   <= w_next_count;
            r_empty_n <= (w_next_count != CW'(0));
            r_full_n  <= (w_next_count != CW'(DEPTH));
        end
    end

`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
    logic r_almost_full;
    logic r_almost_empty;

    // Threshold flags follow the same next-count timing as full/empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_next_count >= CW'(AF_LEVEL));
            r_almost_empty <= (w_next_count <= CW'(AE_LEVEL));
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    fifo_pixelq_srl_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk    (clk),
        .i_ce   (w_shift),
        .i_data (if_din),
        .i_idx  (w_head_idx),
        .o_q_c  (if_dout)
    );

    assign count      = r_count;
    assign if_full_n  = r_full_n;
    assign if_empty_n = r_empty_n;

endmodule

// File: tb/tb_fifo_pixelq_srl_ctrl.sv
// Self-checking bench for fifo_pixelq_srl_ctrl: queue reference model
// compared every cycle, plus directed literal checks from the test plan.
module tb_fifo_pixelq_srl_ctrl;

    localparam int DW    = 12;
    localparam int DEPTH = 3;
    localparam int AW    = 2;

    logic          clk;
    logic          reset_n;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   count;
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int n_pass  = 0;
    int n_total = 0;

    fifo_pixelq_srl_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .count      (count)
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue, oldest word at the front.
    logic [DW-1:0] m_q[$];
    bit            m_valid = 0;

    always @(posedge clk) begin
        bit do_wr;
        bit do_rd;
        if (!reset_n) begin
            m_q.delete();
            m_valid = 1;
        end else if (m_valid) begin
            do_wr = if_write && (m_q.size() < DEPTH);
            do_rd = if_read && (m_q.size() > 0);
            if (do_rd) void'(m_q.pop_front());
            if (do_wr) m_q.push_back(if_din);
        end
    end

    // Compare DUT against the model on every falling edge once reset was seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_count",   32'(count),      32'(m_q.size()));
            chk("m_empty_n", 32'(if_empty_n), 32'(m_q.size() != 0));
            chk("m_full_n",  32'(if_full_n),  32'(m_q.size() != DEPTH));
            if (m_q.size() > 0) chk("m_dout", 32'(if_dout), 32'(m_q[0]));
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
            chk("m_almost_full",  32'(almost_full),  32'(m_q.size() >= DEPTH - 1));
            chk("m_almost_empty", 32'(almost_empty), 32'(m_q.size() <= 1));
`endif
        end
    end

    // One clock with the given strobes; returns 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        if_write = w;
        if_read  = r;
        if_din   = d;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        cyc(1'b1, 1'b1, 12'h3C3);
        cyc(1'b0, 1'b0, 12'h000);
        reset_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty_n", 32'(if_empty_n), 32'd0);
        chk("rst_full_n", 32'(if_full_n), 32'd1);
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
`endif

        // Fill to full.
        cyc(1'b1, 1'b0, 12'h001);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_dout", 32'(if_dout), 32'h001);
        cyc(1'b1, 1'b0, 12'h002);
        chk("fill2_count", 32'(count), 32'd2);
        chk("fill2_dout", 32'(if_dout), 32'h001);
        cyc(1'b1, 1'b0, 12'h003);
        chk("fill3_count", 32'(count), 32'd3);
        chk("fill3_full_n", 32'(if_full_n), 32'd0);
        chk("fill3_dout", 32'(if_dout), 32'h001);

        // Drain in order.
        cyc(1'b0, 1'b1, 12'h000);
        chk("drain1_dout", 32'(if_dout), 32'h002);
        cyc(1'b0, 1'b1, 12'h000);
        chk("drain2_dout", 32'(if_dout), 32'h003);
        cyc(1'b0, 1'b1, 12'h000);
        chk("drain3_empty_n", 32'(if_empty_n), 32'd0);
        chk("drain3_count", 32'(count), 32'd0);

        // Empty with both strobes: only the write lands.
        cyc(1'b1, 1'b1, 12'hABC);
        chk("ew_count", 32'(count), 32'd1);
        chk("ew_dout", 32'(if_dout), 32'hABC);
        chk("ew_empty_n", 32'(if_empty_n), 32'd1);

        // Full with both strobes: only the read lands.
        cyc(1'b1, 1'b0, 12'h111);
        cyc(1'b1, 1'b0, 12'h222);
        chk("f2_full_n", 32'(if_full_n), 32'd0);
        cyc(1'b1, 1'b1, 12'h555);
        chk("fb_count", 32'(count), 32'd2);
        chk("fb_dout", 32'(if_dout), 32'h111);
        chk("fb_full_n", 32'(if_full_n), 32'd1);
        cyc(1'b1, 1'b0, 12'h555);
        chk("retry_count", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 12'h000);
        chk("post1_dout", 32'(if_dout), 32'h222);
        cyc(1'b0, 1'b1, 12'h000);
        chk("post2_dout", 32'(if_dout), 32'h555);
        cyc(1'b0, 1'b1, 12'h000);
        chk("post3_count", 32'(count), 32'd0);

        // Steady streaming at count 2.
        cyc(1'b1, 1'b0, 12'h100);
        cyc(1'b1, 1'b0, 12'h101);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 12'(12'h102 + i));
            chk("stream_count", 32'(count), 32'd2);
            chk("stream_dout", 32'(if_dout), 32'(12'h101 + i));
        end

        // One-cycle reset at count 2, strobes active during it.
        reset_n = 1'b0;
        cyc(1'b1, 1'b1, 12'h777);
        reset_n = 1'b1;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty_n", 32'(if_empty_n), 32'd0);
        chk("mr_full_n", 32'(if_full_n), 32'd1);
`ifdef FIFO_PIXELQ_ALMOST_FLAGS_EN
        chk("mr_af", 32'(almost_full), 32'd0);
        chk("mr_ae", 32'(almost_empty), 32'd1);
`endif
        cyc(1'b0, 1'b0, 12'h000);
        chk("mr_idle_count", 32'(count), 32'd0);
        cyc(1'b1, 1'b0, 12'h0AA);
        chk("after_rst_count", 32'(count), 32'd1);
        chk("after_rst_dout", 32'(if_dout), 32'h0AA);

        cyc(1'b0, 1'b0, 12'h000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
